// File: rtl/dcache_data_array_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : dcache_data_array_arb_pkg
// Brief  : Shared dcache data-array geometry, arbiter FSM states and requester ids.
// Rev    : 1.0 - initial release
// ============================================================================
package dcache_data_array_arb_pkg;

  localparam int INDEX_W = 6;
  localparam int WAY_W   = 3;
  localparam int BANK_W  = 2;
  localparam int DATA_W  = 128;
  localparam int STRB_W  = 16;
  localparam int BEATS   = 4;

  localparam logic [BANK_W-1:0] LAST_BEAT = BANK_W'(BEATS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  localparam logic REQ_HIT_READ  = 1'b0;
  localparam logic REQ_HIT_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dcache_data_array_arb.sv
`default_nettype none
// ============================================================================
// Module : dcache_data_array_arb
// Brief  : Single-port dcache data-array arbiter: hit read, hit write, 4-beat refill.
// Rev    : 1.0 - initial release
// ============================================================================
import dcache_data_array_arb_pkg::*;

module dcache_data_array_arb #(
  parameter int INDEX_W = dcache_data_array_arb_pkg::INDEX_W,
  parameter int WAY_W   = dcache_data_array_arb_pkg::WAY_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hr_valid,
  input  logic [INDEX_W-1:0]  hr_index,
  input  logic [WAY_W-1:0]    hr_way,
  input  logic [1:0]          hr_offset,
  output logic                hr_ready,
  output logic                hr_rvalid,
  output logic [127:0]        hr_rdata,
  input  logic                hw_valid,
  input  logic [INDEX_W-1:0]  hw_index,
  input  logic [WAY_W-1:0]    hw_way,
  input  logic [1:0]          hw_offset,
  input  logic [127:0]        hw_wdata,
  input  logic [15:0]         hw_wstrb,
  output logic                hw_ready,
  input  logic                rf_valid,
  input  logic [INDEX_W-1:0]  rf_index,
  input  logic [WAY_W-1:0]    rf_way,
  input  logic [127:0]        rf_wdata,
  output logic                rf_ready,
  output logic                rf_last,
  output logic                da_valid,
  output logic                da_we,
  output logic [INDEX_W-1:0]  da_index,
  output logic [WAY_W-1:0]    da_way,
  output logic [1:0]          da_offset,
  output logic [127:0]        da_wdata,
  output logic [15:0]         da_wstrb,
  input  logic [127:0]        da_rdata
);

  state_t              r_state;
  logic [BANK_W-1:0]   r_cnt;
  logic [INDEX_W-1:0]  r_index;
  logic [WAY_W-1:0]    r_way;
  logic                r_rr;
  logic                r_rd_pend;

  logic w_in_idle;
  logic w_rf_grant;
  logic w_hit_ok;
  logic w_hr_grant;
  logic w_hw_grant;

  // Refill owns the array whenever it presents a beat; hits only contend in IDLE.
  assign w_in_idle  = (r_state == ST_IDLE);
  assign w_rf_grant = !reset && rf_valid;
  assign w_hit_ok   = !reset && w_in_idle && !rf_valid;
  assign w_hr_grant = w_hit_ok && hr_valid && (!hw_valid || (r_rr == REQ_HIT_READ));
  assign w_hw_grant = w_hit_ok && hw_valid && (!hr_valid || (r_rr == REQ_HIT_WRITE));

  assign hr_ready  = w_hr_grant;
  assign hw_ready  = w_hw_grant;
  assign rf_ready  = w_rf_grant;
  assign rf_last   = w_rf_grant && !w_in_idle && (r_cnt == LAST_BEAT);
  assign da_valid  = w_hr_grant || w_hw_grant || w_rf_grant;
  assign hr_rvalid = r_rd_pend && !reset;
  assign hr_rdata  = hr_rvalid ? da_rdata : '0;

  always_comb begin
    da_we     = 1'b0;
    da_index  = '0;
    da_way    = '0;
    da_offset = '0;
    da_wdata  = '0;
    da_wstrb  = '0;
    if (w_rf_grant) begin
      // Beat 0 goes straight from the request; later beats use the latched line.
      da_we     = 1'b1;
      da_index  = w_in_idle ? rf_index : r_index;
      da_way    = w_in_idle ? rf_way   : r_way;
      da_offset = w_in_idle ? '0       : r_cnt;
      da_wdata  = rf_wdata;
      da_wstrb  = '1;
    end else if (w_hw_grant) begin
      da_we     = 1'b1;
      da_index  = hw_index;
      da_way    = hw_way;
      da_offset = hw_offset;
      da_wdata  = hw_wdata;
      da_wstrb  = hw_wstrb;
    end else if (w_hr_grant) begin
      da_index  = hr_index;
      da_way    = hr_way;
      da_offset = hr_offset;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_index   <= '0;
      r_way     <= '0;
      r_rr      <= REQ_HIT_READ;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_hr_grant;
      if (w_hr_grant) begin
        r_rr <= REQ_HIT_WRITE;
      end else if (w_hw_grant) begin
        r_rr <= REQ_HIT_READ;
      end
      if (w_rf_grant) begin
        if (w_in_idle) begin
          r_index <= rf_index;
          r_way   <= rf_way;
          r_cnt   <= BANK_W'(1);
          r_state <= ST_REFILL;
        end else if (r_cnt == LAST_BEAT) begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end else begin
          r_cnt   <= r_cnt + BANK_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_data_array_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_data_array_arb
// Brief  : Per-cycle vector table with a read-return scoreboard for the array arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dcache_data_array_arb;

  localparam logic [5:0]   HW_IDX  = 6'd33;
  localparam logic [2:0]   HW_WAY  = 3'd6;
  localparam logic [1:0]   HW_OFF  = 2'd3;
  localparam logic [127:0] HW_DATA = {4{32'h1111_2222}};
  localparam logic [15:0]  HW_STRB = 16'h00F0;

  typedef struct {
    logic       rst;
    logic       hr_v;
    logic [5:0] hr_i;
    logic [2:0] hr_w;
    logic [1:0] hr_o;
    logic       hw_v;
    logic       rf_v;
    logic [5:0] rf_i;
    logic [2:0] rf_w;
    logic       e_hr;
    logic       e_hw;
    logic       e_rf;
    logic       e_last;
    logic [5:0] e_i;
    logic [2:0] e_w;
    logic [1:0] e_o;
    logic       e_rv;
  } vec_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         hr_valid, hw_valid, rf_valid;
  logic [5:0]   hr_index, hw_index, rf_index, da_index;
  logic [2:0]   hr_way, hw_way, rf_way, da_way;
  logic [1:0]   hr_offset, hw_offset, da_offset;
  logic         hr_ready, hr_rvalid, hw_ready, rf_ready, rf_last;
  logic         da_valid, da_we;
  logic [127:0] hr_rdata, hw_wdata, rf_wdata, da_wdata, da_rdata;
  logic [15:0]  hw_wstrb, da_wstrb;

  int           checks = 0;
  int           failures = 0;
  vec_t         vecs[$];
  logic [127:0] sb_q[$];

  always #5 clock = ~clock;

  dcache_data_array_arb #(.INDEX_W(6), .WAY_W(3)) dut (
    .clock(clock), .reset(reset),
    .hr_valid(hr_valid), .hr_index(hr_index), .hr_way(hr_way), .hr_offset(hr_offset),
    .hr_ready(hr_ready), .hr_rvalid(hr_rvalid), .hr_rdata(hr_rdata),
    .hw_valid(hw_valid), .hw_index(hw_index), .hw_way(hw_way), .hw_offset(hw_offset),
    .hw_wdata(hw_wdata), .hw_wstrb(hw_wstrb), .hw_ready(hw_ready),
    .rf_valid(rf_valid), .rf_index(rf_index), .rf_way(rf_way), .rf_wdata(rf_wdata),
    .rf_ready(rf_ready), .rf_last(rf_last),
    .da_valid(da_valid), .da_we(da_we), .da_index(da_index), .da_way(da_way),
    .da_offset(da_offset), .da_wdata(da_wdata), .da_wstrb(da_wstrb), .da_rdata(da_rdata)
  );

  function automatic logic [127:0] pattern(input logic [5:0] i, input logic [2:0] w,
                                           input logic [1:0] o);
    return {96'hDEAD_BEEF_0123_4567_89AB_CDEF, 21'd0, i, w, o};
  endfunction

  // Array stub: returns an address-derived word after a read, junk otherwise.
  always @(posedge clock) begin
    if (da_valid && !da_we) da_rdata <= pattern(da_index, da_way, da_offset);
    else                    da_rdata <= {$urandom, $urandom, $urandom, $urandom | 32'h1};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp,
                     input int n);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s: got %h expected %h", n, name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
      input logic rst, input logic hr_v, input logic [5:0] hr_i, input logic [2:0] hr_w,
      input logic [1:0] hr_o, input logic hw_v, input logic rf_v, input logic [5:0] rf_i,
      input logic [2:0] rf_w, input logic e_hr, input logic e_hw, input logic e_rf,
      input logic e_last, input logic [5:0] e_i, input logic [2:0] e_w, input logic [1:0] e_o,
      input logic e_rv);
    vec_t v;
    v.rst = rst; v.hr_v = hr_v; v.hr_i = hr_i; v.hr_w = hr_w; v.hr_o = hr_o;
    v.hw_v = hw_v; v.rf_v = rf_v; v.rf_i = rf_i; v.rf_w = rf_w;
    v.e_hr = e_hr; v.e_hw = e_hw; v.e_rf = e_rf; v.e_last = e_last;
    v.e_i = e_i; v.e_w = e_w; v.e_o = e_o; v.e_rv = e_rv;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int n);
    logic [127:0] rfd;
    logic [127:0] exp_wd;
    logic [15:0]  exp_ws;
    logic [127:0] exp_rd;
    @(posedge clock);
    #1;
    rfd       = {4{32'hC0DE_0000 + 32'(n)}};
    reset     = v.rst;
    hr_valid  = v.hr_v; hr_index = v.hr_i; hr_way = v.hr_w; hr_offset = v.hr_o;
    hw_valid  = v.hw_v; hw_index = HW_IDX; hw_way = HW_WAY; hw_offset = HW_OFF;
    hw_wdata  = HW_DATA; hw_wstrb = HW_STRB;
    rf_valid  = v.rf_v; rf_index = v.rf_i; rf_way = v.rf_w; rf_wdata = rfd;
    if (v.e_hr) sb_q.push_back(pattern(v.hr_i, v.hr_w, v.hr_o));
    exp_wd = v.e_rf ? rfd : (v.e_hw ? HW_DATA : '0);
    exp_ws = v.e_rf ? 16'hFFFF : (v.e_hw ? HW_STRB : 16'h0);
    @(negedge clock);
    chk("hr_ready",  128'(hr_ready),  128'(v.e_hr), n);
    chk("hw_ready",  128'(hw_ready),  128'(v.e_hw), n);
    chk("rf_ready",  128'(rf_ready),  128'(v.e_rf), n);
    chk("rf_last",   128'(rf_last),   128'(v.e_last), n);
    chk("da_valid",  128'(da_valid),  128'(v.e_hr | v.e_hw | v.e_rf), n);
    chk("da_we",     128'(da_we),     128'(v.e_hw | v.e_rf), n);
    chk("da_index",  128'(da_index),  128'(v.e_i), n);
    chk("da_way",    128'(da_way),    128'(v.e_w), n);
    chk("da_offset", 128'(da_offset), 128'(v.e_o), n);
    chk("da_wdata",  da_wdata,        exp_wd, n);
    chk("da_wstrb",  128'(da_wstrb),  128'(exp_ws), n);
    chk("hr_rvalid", 128'(hr_rvalid), 128'(v.e_rv), n);
    exp_rd = '0;
    if (v.e_rv) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL vec%0d sb_underflow: got empty scoreboard expected a pending read", n);
      end else begin
        exp_rd = sb_q.pop_front();
      end
    end
    chk("hr_rdata", hr_rdata, exp_rd, n);
  endtask

  initial begin
    reset = 1'b1;
    hr_valid = 0; hw_valid = 0; rf_valid = 0;
    hr_index = 0; hr_way = 0; hr_offset = 0;
    hw_index = 0; hw_way = 0; hw_offset = 0; hw_wdata = 0; hw_wstrb = 0;
    rf_index = 0; rf_way = 0; rf_wdata = 0;

    //                rst hr i  w o  hw rf i  w  ehr ehw erf lst ei  ew eo rv
    vecs.push_back(mkv(1, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 0));
    vecs.push_back(mkv(1, 1, 5, 2,1, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 0));
    vecs.push_back(mkv(0, 1, 5, 2,1, 0, 0, 0, 0, 1,  0,  0,  0,  5, 2,1, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 1));
    // round robin after a fresh reset
    vecs.push_back(mkv(1, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 0));
    vecs.push_back(mkv(0, 1, 1, 0,2, 1, 0, 0, 0, 1,  0,  0,  0,  1, 0,2, 0));
    vecs.push_back(mkv(0, 1, 1, 0,2, 1, 0, 0, 0, 0,  1,  0,  0, 33, 6,3, 1));
    vecs.push_back(mkv(0, 1, 1, 0,2, 1, 0, 0, 0, 1,  0,  0,  0,  1, 0,2, 0));
    vecs.push_back(mkv(0, 1, 1, 0,2, 1, 0, 0, 0, 0,  1,  0,  0, 33, 6,3, 1));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 1, 0, 0, 0, 0,  1,  0,  0, 33, 6,3, 0));
    // refill beats over a waiting hit read
    vecs.push_back(mkv(0, 1, 5, 2,1, 0, 1, 9, 7, 0,  0,  1,  0,  9, 7,0, 0));
    vecs.push_back(mkv(0, 1, 5, 2,1, 0, 1, 9, 7, 0,  0,  1,  0,  9, 7,1, 0));
    vecs.push_back(mkv(0, 1, 5, 2,1, 0, 1, 9, 7, 0,  0,  1,  0,  9, 7,2, 0));
    vecs.push_back(mkv(0, 1, 5, 2,1, 0, 1, 9, 7, 0,  0,  1,  1,  9, 7,3, 0));
    vecs.push_back(mkv(0, 1, 5, 2,1, 0, 0, 0, 0, 1,  0,  0,  0,  5, 2,1, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 1));
    // bubble mid-burst, rf_index/rf_way change after beat 0
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,12, 3, 0,  0,  1,  0, 12, 3,0, 0));
    vecs.push_back(mkv(0, 1, 5, 2,1, 1, 0,40, 1, 0,  0,  0,  0,  0, 0,0, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,40, 1, 0,  0,  1,  0, 12, 3,1, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,40, 1, 0,  0,  1,  0, 12, 3,2, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,40, 1, 0,  0,  1,  1, 12, 3,3, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 0));
    // read then refill start, then reset after beat 1
    vecs.push_back(mkv(0, 1, 7, 1,3, 0, 0, 0, 0, 1,  0,  0,  0,  7, 1,3, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,20, 5, 0,  0,  1,  0, 20, 5,0, 1));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,20, 5, 0,  0,  1,  0, 20, 5,1, 0));
    vecs.push_back(mkv(1, 1, 7, 1,3, 0, 1,20, 5, 0,  0,  0,  0,  0, 0,0, 0));
    vecs.push_back(mkv(0, 1, 7, 1,3, 0, 0, 0, 0, 1,  0,  0,  0,  7, 1,3, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,21, 2, 0,  0,  1,  0, 21, 2,0, 1));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,21, 2, 0,  0,  1,  0, 21, 2,1, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,21, 2, 0,  0,  1,  0, 21, 2,2, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 1,21, 2, 0,  0,  1,  1, 21, 2,3, 0));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 0));
    // streaming hit reads
    vecs.push_back(mkv(0, 1,10, 3,0, 0, 0, 0, 0, 1,  0,  0,  0, 10, 3,0, 0));
    vecs.push_back(mkv(0, 1,11, 4,1, 0, 0, 0, 0, 1,  0,  0,  0, 11, 4,1, 1));
    vecs.push_back(mkv(0, 1,12, 5,2, 0, 0, 0, 0, 1,  0,  0,  0, 12, 5,2, 1));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 1));
    vecs.push_back(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0,0, 0));

    for (int n = 0; n < vecs.size(); n++) apply(vecs[n], n);

    // Reset landing on the return cycle of a granted read suppresses the return.
    apply(mkv(0, 1, 3, 3,3, 0, 0, 0, 0, 1, 0, 0, 0, 3, 3,3, 0), 100);
    apply(mkv(1, 0, 0, 0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,0, 0), 101);
    void'(sb_q.pop_front());
    apply(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,0, 0), 102);

    // After reset rr points at hit read again even though hw was not last granted.
    apply(mkv(0, 1, 2, 1,0, 1, 0, 0, 0, 1, 0, 0, 0, 2, 1,0, 0), 103);
    apply(mkv(0, 0, 0, 0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,0, 1), 104);

    chk("sb_drained", 128'(sb_q.size()), 128'(0), 999);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
